sram_line_ctrl: RTL and testbench

//  Memory-side responder for the MEM-stage data cache: services read misses with a 64-bit line fill and write-through stores.

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_beat_timer.sv | 33 +++
 rtl/sram_line_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sram_line_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared sizes, FSM encoding and read-lane mapping for the SRAM line controller.
// Consumed by sram_line_ctrl and sram_beat_timer.
package sram_pkg;

  localparam int LINE_BEATS = 4;
  localparam int WORD_BEATS = 2;
  localparam int SRAM_AW    = 18;
  localparam int SRAM_DW    = 16;
  localparam int LINE_W     = 64;
  localparam int ADDR_W     = 19;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_WR   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Halfword lane of the line (3 = [63:48]) filled by a read beat; word addr[2]=0 sits in the upper half.
  function automatic logic [1:0] rd_lane(input logic [1:0] beat);
    return {~beat[1], beat[0]};
  endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Per-beat wait counter (0..SRAM_WAIT) for SRAM halfword accesses; cleared when a request is accepted.
// o_beat_last marks the final cycle of a beat, o_beat_done qualifies it with an active transfer.
module sram_beat_timer
  import sram_pkg::*;
#(
  parameter int SRAM_WAIT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_beat_last,
  output logic o_beat_done
);

  localparam int CW = $clog2(SRAM_WAIT + 1);

  logic [CW-1:0] r_wait;

  assign o_beat_last = (r_wait == CW'(SRAM_WAIT));
  assign o_beat_done = i_run & o_beat_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait <= '0;
    end else if (i_clr || o_beat_done) begin
      r_wait <= '0;
    end else if (i_run) begin
      r_wait <= r_wait + 1'b1;
    end
  end

endmodule

// File: rtl/sram_line_ctrl.sv
// Cache-side SRAM responder: 4-beat 64-bit line fills, 2-beat 32-bit write-through stores; freeze until ready.
// Latency read 4*(SRAM_WAIT+1)+1, write 2*(SRAM_WAIT+1)+1; SRAM_WRITE_BUFFER_EN posts writes (ready next cycle).
module sram_line_ctrl
  import sram_pkg::*;
#(
  parameter int SRAM_WAIT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_read_en,
  input  logic               i_write_en,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [31:0]        i_write_data,
  output logic               o_ready,
  output logic               o_freeze,
  output logic [LINE_W-1:0]  o_line_data,
  output logic               o_cch_update,
  output logic [SRAM_AW-1:0] o_sram_addr,
  inout  wire  [SRAM_DW-1:0] io_sram_dq,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_ce_n,
  output logic               o_sram_ub_n,
  output logic               o_sram_lb_n
);

  state_t              r_state;
  logic [1:0]          r_beat;
  logic [ADDR_W-3:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_op_rd;
  logic [LINE_W-1:0]   r_line;

  logic                w_accept_wr;
  logic                w_accept_rd;
  logic                w_accept;
  logic                w_run;
  logic                w_beat_last;
  logic                w_beat_done;
  logic [1:0]          w_lane;
  logic                w_dq_oe;
  logic [SRAM_DW-1:0]  w_dq_out;
  logic                w_unused;

  // Write wins when both requests are presented in the same cycle.
  assign w_accept_wr = (r_state == ST_IDLE) & i_write_en;
  assign w_accept_rd = (r_state == ST_IDLE) & ~i_write_en & i_read_en;
  assign w_accept    = w_accept_wr | w_accept_rd;
  assign w_run       = (r_state == ST_RD) | (r_state == ST_WR);
  assign w_lane      = rd_lane(r_beat);
  assign w_unused    = ^i_addr[1:0];

  sram_beat_timer #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_beat_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (w_accept),
    .i_run       (w_run),
    .o_beat_last (w_beat_last),
    .o_beat_done (w_beat_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_rd <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= w_accept_wr ? ST_WR : ST_RD;
            r_beat  <= '0;
            r_addr  <= i_addr[ADDR_W-1:2];
            r_wdata <= i_write_data;
            r_op_rd <= w_accept_rd;
          end
        end
        ST_RD: begin
          if (w_beat_done) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == 2'(LINE_BEATS - 1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_WR: begin
          if (w_beat_done) begin
            if (r_beat == 2'(WORD_BEATS - 1)) begin
              r_state <= ST_DONE;
              r_beat  <= '0;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Each halfword is sampled on the last cycle of its beat, after SRAM access time has elapsed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line <= '0;
    end else if ((r_state == ST_RD) && w_beat_done) begin
      r_line[{w_lane, 4'h0} +: SRAM_DW] <= io_sram_dq;
    end
  end

  always_comb begin
    o_sram_addr = '0;
    o_sram_we_n = 1'b1;
    o_sram_oe_n = 1'b1;
    o_sram_ce_n = 1'b1;
    o_sram_ub_n = 1'b1;
    o_sram_lb_n = 1'b1;
    w_dq_oe     = 1'b0;
    w_dq_out    = '0;
    case (r_state)
      ST_RD: begin
        o_sram_addr = {r_addr[ADDR_W-3:1], r_beat};
        o_sram_ce_n = 1'b0;
        o_sram_oe_n = 1'b0;
        o_sram_ub_n = 1'b0;
        o_sram_lb_n = 1'b0;
      end
      ST_WR: begin
        // we_n rises into the last cycle of the beat while address and data stay put.
        o_sram_addr = {r_addr, r_beat[0]};
        o_sram_ce_n = 1'b0;
        o_sram_ub_n = 1'b0;
        o_sram_lb_n = 1'b0;
        o_sram_we_n = w_beat_last;
        w_dq_oe     = 1'b1;
        w_dq_out    = r_beat[0] ? r_wdata[31:16] : r_wdata[15:0];
      end
      default: begin
      end
    endcase
  end

  assign io_sram_dq = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};

`ifdef SRAM_WRITE_BUFFER_EN
  logic r_posted;
  logic r_post_ack;

  // A posted write is acknowledged immediately; its own DONE must then stay silent.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_posted   <= 1'b0;
      r_post_ack <= 1'b0;
    end else begin
      r_post_ack <= w_accept_wr;
      if (w_accept_wr) begin
        r_posted <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_posted <= 1'b0;
      end
    end
  end

  assign o_ready = r_post_ack | ((r_state == ST_DONE) & ~r_posted);
`else
  assign o_ready = (r_state == ST_DONE);
`endif

  assign o_cch_update = (r_state == ST_DONE) & r_op_rd;
  assign o_freeze     = (i_read_en | i_write_en) & ~o_ready;
  assign o_line_data  = r_line;

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Scoreboard bench for sram_line_ctrl against a behavioural asynchronous 16-bit SRAM.
// Define SRAM_WRITE_BUFFER_EN for both bench and RTL to cover the posted-write build.
`timescale 1ns/1ps
module tb_sram_line_ctrl;

  localparam int W      = 1;
  localparam int RD_LAT = 4 * (W + 1) + 1;
  localparam int WR_LAT = 2 * (W + 1) + 1;
`ifdef SRAM_WRITE_BUFFER_EN
  localparam int WR_EXP = 1;
  localparam int B2B_RD = WR_LAT + RD_LAT;
`else
  localparam int WR_EXP = WR_LAT;
  localparam int B2B_RD = RD_LAT + 1;
`endif

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        read_en  = 1'b0;
  logic        write_en = 1'b0;
  logic [18:0] addr     = '0;
  logic [31:0] wdata    = '0;
  logic        ready, freeze, cch;
  logic [63:0] line;
  logic [17:0] sram_addr;
  tri1  [15:0] sram_dq;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  logic [15:0] mem [0:1023];
  int cyc    = 0;
  int oe_cnt = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct {
    bit          is_rd;
    logic [63:0] line;
    int          lat;
    int          issue;
  } exp_t;
  exp_t sb[$];

  sram_line_ctrl #(.SRAM_WAIT(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_read_en    (read_en),
    .i_write_en   (write_en),
    .i_addr       (addr),
    .i_write_data (wdata),
    .o_ready      (ready),
    .o_freeze     (freeze),
    .o_line_data  (line),
    .o_cch_update (cch),
    .o_sram_addr  (sram_addr),
    .io_sram_dq   (sram_dq),
    .o_sram_we_n  (we_n),
    .o_sram_oe_n  (oe_n),
    .o_sram_ce_n  (ce_n),
    .o_sram_ub_n  (ub_n),
    .o_sram_lb_n  (lb_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

  initial begin : sram_model
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h040] = 16'h1111;
    mem[10'h041] = 16'h2222;
    mem[10'h042] = 16'h3333;
    mem[10'h043] = 16'h4444;
    mem[10'h082] = 16'hAAAA;
    mem[10'h083] = 16'hBBBB;
    forever begin
      @(posedge we_n);
      if (!ce_n) mem[sram_addr[9:0]] = sram_dq;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},   64'(ready), 64'd0);
    chk({tag, "_cch"},     64'(cch), 64'd0);
    chk({tag, "_strobes"}, 64'({we_n, oe_n, ce_n, ub_n, lb_n}), 64'h1f);
    chk({tag, "_dq_hiz"},  64'(sram_dq), 64'hffff);
    chk({tag, "_addr"},    64'(sram_addr), 64'd0);
    chk({tag, "_line"},    line, 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!oe_n) oe_cnt++;
    if (cch && !ready) chk("cch_without_ready", 64'(cch), 64'd0);
    if (ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'(ready), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("cch_update", 64'(cch), 64'(e.is_rd));
        if (e.is_rd) chk("line_data", line, e.line);
        chk("latency", 64'(cyc - e.issue), 64'(e.lat));
      end
    end
  end

  // Called at a negedge; returns at the negedge where ready was seen.
  task automatic do_req(input bit rd, input bit wr, input logic [18:0] a, input logic [31:0] d,
                        input logic [63:0] exp_line, input int exp_lat, input bit scramble);
    exp_t e;
    int   waited;
    bit   got;
    e.is_rd = rd & ~wr;
    e.line  = exp_line;
    e.lat   = exp_lat;
    e.issue = cyc;
    sb.push_back(e);
    read_en  = rd;
    write_en = wr;
    addr     = a;
    wdata    = d;
    waited   = 0;
    got      = 1'b0;
    while (!got && waited < 64) begin
      @(negedge clk);
      waited++;
      if (waited == 1) begin
        chk("freeze", 64'(freeze), 64'(exp_lat > 1));
        if (scramble) begin
          addr  = 19'($urandom);
          wdata = $urandom;
        end
      end
      if (ready) got = 1'b1;
    end
    if (!got) begin
      chk("ready_timeout", 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    read_en  = 1'b0;
    write_en = 1'b0;
  endtask

  initial begin : stim
    int          base;
    logic [31:0] d;
    logic [18:0] a;
    logic [63:0] exp_line;

    #2 rst_n = 1'b0;
    #1 chk_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Abort a line fill partway through with an asynchronous reset.
    @(negedge clk);
    read_en = 1'b1;
    addr    = 19'h00080;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 read_en = 1'b0;
    chk_idle("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    base = oe_cnt;
    do_req(1'b1, 1'b0, 19'h00080, 32'h0, 64'h2222_1111_4444_3333, RD_LAT, 1'b1);
    chk("read_oe_cycles", 64'(oe_cnt - base), 64'(4 * (W + 1)));
    repeat (4) @(negedge clk);

    do_req(1'b0, 1'b1, 19'h00084, 32'hDEADBEEF, 64'h0, WR_EXP, 1'b1);
    repeat (8) @(negedge clk);
    chk("wr_lo_half", 64'(mem[10'h042]), 64'hBEEF);
    chk("wr_hi_half", 64'(mem[10'h043]), 64'hDEAD);

    base = oe_cnt;
    do_req(1'b1, 1'b1, 19'h00100, 32'h12345678, 64'h0, WR_EXP, 1'b0);
    repeat (8) @(negedge clk);
    chk("both_no_read_beats", 64'(oe_cnt - base), 64'd0);
    chk("both_wr_lo", 64'(mem[10'h080]), 64'h5678);
    chk("both_wr_hi", 64'(mem[10'h081]), 64'h1234);
    do_req(1'b1, 1'b0, 19'h00100, 32'h0, 64'h1234_5678_BBBB_AAAA, RD_LAT, 1'b0);
    repeat (4) @(negedge clk);

    do_req(1'b0, 1'b1, 19'h00084, 32'hCAFEF00D, 64'h0, WR_EXP, 1'b0);
    do_req(1'b1, 1'b0, 19'h00080, 32'h0, 64'h2222_1111_CAFE_F00D, B2B_RD, 1'b0);
    repeat (4) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      d        = $urandom;
      a        = 19'h00200 + 19'(8 * k) + ((k % 2 == 1) ? 19'd4 : 19'd0);
      exp_line = (k % 2 == 1) ? {32'h0, d} : {d, 32'h0};
      do_req(1'b0, 1'b1, a, d, 64'h0, WR_EXP, 1'b0);
      do_req(1'b1, 1'b0, 19'h00200 + 19'(8 * k), 32'h0, exp_line, B2B_RD, 1'b0);
      repeat (4) @(negedge clk);
    end

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles, expected fewer", cyc);
    $fatal(1);
  end

endmodule
